// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and fetch PC constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch queue of {pc, instr} pairs with flush and a registered head.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             pop_ok;

  assign pop_ok = pop && (count != '0);

  // Head is precomputed so the output stays a flop; a push that lands where the
  // read pointer will be next cycle bypasses the storage array.
  always_comb begin
    rd_nxt = rd_ptr + AW'(pop_ok);
    if (push && (wr_ptr == rd_nxt)) begin
      head_nxt = din;
    end else begin
      head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_nxt;
      end
      head <= head_nxt;
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requester feeding a prefetch queue.
// state     | meaning
// S_IDLE    | no request outstanding
// S_WAIT    | one request outstanding, response will be queued
// S_DISCARD | one request outstanding, response will be dropped
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DWIDTH-1:0] RESET_PC = DWIDTH'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DWIDTH-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [DWIDTH-1:0] redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [DWIDTH-1:0] if_pc,
  output logic [DWIDTH-1:0] if_instr
);

  localparam int                CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]     DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [DWIDTH-1:0] INC      = DWIDTH'(PC_INC);

  fetch_state_t        state;
  fetch_state_t        state_nxt;
  logic [DWIDTH-1:0]   fetch_pc;
  logic [DWIDTH-1:0]   req_pc;
  logic [CW-1:0]       count;
  logic [2*DWIDTH-1:0] head;
  logic                accept;
  logic                push;
  logic                pop;

  // Space check uses registered count only; an issue from S_WAIT must also
  // leave room for the response being pushed this cycle.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      S_IDLE:  imem_req = (count < DEPTH_C) && !redirect && !rst;
      S_WAIT:  imem_req = imem_rvalid && (count < DEPTH_M1) && !redirect && !rst;
      default: imem_req = 1'b0;
    endcase
  end

  assign accept = imem_req && imem_ready;
  assign push   = (state == S_WAIT) && imem_rvalid && !redirect;
  assign pop    = if_valid && !stall && !redirect;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_nxt = imem_rvalid ? S_IDLE : S_DISCARD;
        end else if (imem_rvalid) begin
          state_nxt = accept ? S_WAIT : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (accept) begin
        fetch_pc <= fetch_pc + INC;
      end
      if (accept) begin
        req_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2 * DWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({req_pc, imem_rdata}),
    .head  (head),
    .count (count)
  );

  assign imem_addr = fetch_pc;
  assign if_valid  = (count != '0);
  assign if_pc     = head[2*DWIDTH-1:DWIDTH];
  assign if_instr  = head[DWIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.DWIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  always #5 clk = ~clk;

  // memory: responds lat cycles after acceptance with data = addr >> 2
  int          lat = 1;
  logic        acc = 1'b0;
  logic [31:0] acc_addr = '0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          pwait = 0;

  always @(negedge clk) begin
    if (imem_req && imem_ready) begin
      acc      = 1'b1;
      acc_addr = imem_addr;
    end
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (rst) begin
      acc  = 1'b0;
      pend = 1'b0;
    end else begin
      if (acc) begin
        pend  = 1'b1;
        paddr = acc_addr;
        pwait = lat;
        acc   = 1'b0;
      end
      if (pend) begin
        if (pwait <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = paddr >> 2;
          pend        = 1'b0;
        end else begin
          pwait = pwait - 1;
        end
      end
    end
  end

  // log of entries handed to IF/ID
  logic [31:0] pcs[$];
  logic [31:0] ins[$];

  always @(negedge clk) begin
    if (!rst && if_valid && !stall && !redirect) begin
      pcs.push_back(if_pc);
      ins.push_back(if_instr);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc_at(input int i);
    return (i < pcs.size()) ? pcs[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] in_at(input int i);
    return (i < ins.size()) ? ins[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the caller at the start of cycle 0 after release
  task automatic restart();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pcs.delete();
    ins.delete();
  endtask

  task automatic wait_pops(input int n, input string tag);
    for (int k = 0; k < 30 && pcs.size() < n; k++) tick();
    check_val(tag, 32'(pcs.size() >= n), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", if_valid, 0);
    check_val("rst_pc", if_pc, 0);
    check_val("rst_instr", if_instr, 0);
    check_val("rst_req", imem_req, 0);
    check_val("rst_addr", imem_addr, 0);

    // latency and streaming
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("c0_req", imem_req, 1);
    check_val("c0_addr", imem_addr, 0);
    tick();
    @(negedge clk);
    check_val("c1_valid", if_valid, 0);
    check_val("c1_req", imem_req, 1);
    check_val("c1_addr", imem_addr, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check_val("stream_valid", if_valid, 1);
      check_val("stream_pc", if_pc, 32'(i * 4));
      check_val("stream_instr", if_instr, 32'(i));
    end

    // stall until full, then drain without gaps
    stall = 1'b1;
    restart();
    repeat (10) tick();
    @(negedge clk);
    check_val("full_req", imem_req, 0);
    check_val("full_addr", imem_addr, 32'd16);
    check_val("full_valid", if_valid, 1);
    check_val("full_pc", if_pc, 0);
    tick();
    pcs.delete();
    ins.delete();
    stall = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      check_val("drain_pc", pc_at(i), 32'(i * 4));
      check_val("drain_instr", in_at(i), 32'(i));
    end

    // memory not ready for 3 cycles
    stall = 1'b1;
    imem_ready = 1'b0;
    restart();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("nrdy_req", imem_req, 1);
      check_val("nrdy_addr", imem_addr, 0);
      tick();
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    @(negedge clk);
    check_val("nrdy_valid", if_valid, 1);
    check_val("nrdy_pc", if_pc, 0);
    check_val("nrdy_instr", if_instr, 0);
    check_val("nrdy_next_addr", imem_addr, 32'd4);
    tick();
    pcs.delete();
    ins.delete();
    stall = 1'b0;
    tick();
    @(negedge clk);
    check_val("nrdy_one_push", if_valid, 0);
    check_val("nrdy_pops", 32'(pcs.size()), 1);

    // redirect while a 3-cycle response is outstanding
    imem_ready = 1'b1;
    lat = 3;
    restart();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check_val("disc_req_a", imem_req, 0);
    check_val("disc_valid", if_valid, 0);
    tick();
    @(negedge clk);
    check_val("disc_req_b", imem_req, 0);
    tick();
    @(negedge clk);
    check_val("disc_new_req", imem_req, 1);
    check_val("disc_new_addr", imem_addr, 32'h100);
    wait_pops(1, "disc_pop_seen");
    check_val("disc_first_pc", pc_at(0), 32'h100);
    check_val("disc_first_instr", in_at(0), 32'h40);

    // redirect coinciding with rvalid and a pop
    lat = 1;
    restart();
    repeat (6) tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    pcs.delete();
    ins.delete();
    @(negedge clk);
    check_val("rdr_pre_valid", if_valid, 1);
    check_val("rdr_req", imem_req, 0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check_val("rdr_valid", if_valid, 0);
    check_val("rdr_new_req", imem_req, 1);
    check_val("rdr_new_addr", imem_addr, 32'h200);
    wait_pops(1, "rdr_pop_seen");
    check_val("rdr_first_pc", pc_at(0), 32'h200);
    check_val("rdr_first_instr", in_at(0), 32'h80);

    // fetch address wraps at the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check_val("wrap_addr_a", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check_val("wrap_req", imem_req, 1);
    check_val("wrap_addr_b", imem_addr, 0);

    // async reset between clock edges during streaming
    repeat (4) tick();
    @(negedge clk);
    check_val("arst_pre_valid", if_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_valid", if_valid, 0);
    check_val("arst_pc", if_pc, 0);
    check_val("arst_instr", if_instr, 0);
    check_val("arst_req", imem_req, 0);
    check_val("arst_addr", imem_addr, 0);
    tick();
    tick();
    pcs.delete();
    ins.delete();
    rst = 1'b0;
    @(negedge clk);
    check_val("arst_c0_req", imem_req, 1);
    check_val("arst_c0_addr", imem_addr, 0);
    wait_pops(2, "arst_pops_seen");
    check_val("arst_pc0", pc_at(0), 0);
    check_val("arst_pc1", pc_at(1), 32'd4);
    check_val("arst_instr1", in_at(1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
